// File: rtl/race_turn_controller.sv
// Turn sequencer for the dice race: turns start presses into roll requests, accepts one
// dice value per turn, advances the current player's position and reports the winner.
module race_turn_controller #(
    parameter int TRACK_LEN   = 30,
    parameter int TIMEOUT_CYC = 200_000_000,
    parameter int POS_W       = $clog2(TRACK_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               is_game,
    input  logic               menu_select,
    input  logic               game_start_tick,
    input  logic               dice_valid,
    input  logic [2:0]         dice_value,
    output logic               dice_ready,
    output logic [1:0]         cur_player,
    output logic [4*POS_W-1:0] pos,
    output logic [2:0]         last_roll,
    output logic               roll_err,
    output logic               game_over,
    output logic [1:0]         winner,
    output logic               finished
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    // Extra headroom so position + roll can never wrap before saturation.
    localparam int SUM_W = POS_W + 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [POS_W-1:0] FINISH   = POS_W'(TRACK_LEN);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ROLL,
        WAIT_DICE,
        MOVE,
        CHECK,
        DONE
    } state_t;

    state_t             state_reg;
    logic               start_prev_reg;
    logic               four_players_reg;
    logic [CNT_W-1:0]   timer_reg;
    logic [POS_W-1:0]   pos_reg [4];

    logic               roll_req;
    logic               handshake;
    logic               legal;
    logic [SUM_W-1:0]   sum;
    logic [POS_W-1:0]   moved;

    assign roll_req  = game_start_tick & ~start_prev_reg;
    assign handshake = dice_valid & dice_ready;
    assign legal     = (dice_value != 3'd0) && (dice_value != 3'd7);
    assign sum       = SUM_W'(pos_reg[cur_player]) + SUM_W'(last_roll);
    assign moved     = (sum >= SUM_W'(TRACK_LEN)) ? FINISH : sum[POS_W-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_pos
            assign pos[gi*POS_W +: POS_W] = pos_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            start_prev_reg   <= 1'b0;
            four_players_reg <= 1'b0;
            timer_reg        <= '0;
            for (int i = 0; i < 4; i++) pos_reg[i] <= '0;
            cur_player       <= '0;
            last_roll        <= '0;
            roll_err         <= 1'b0;
            game_over        <= 1'b0;
            winner           <= '0;
            finished         <= 1'b0;
            dice_ready       <= 1'b0;
        end else begin
            roll_err       <= 1'b0;
            game_over      <= 1'b0;
            start_prev_reg <= game_start_tick;
            if (state_reg != IDLE && !is_game) begin
                // Leaving the game screen wipes the whole match.
                state_reg  <= IDLE;
                timer_reg  <= '0;
                for (int i = 0; i < 4; i++) pos_reg[i] <= '0;
                cur_player <= '0;
                last_roll  <= '0;
                winner     <= '0;
                finished   <= 1'b0;
                dice_ready <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (is_game) begin
                            four_players_reg <= menu_select;
                            // A button still held from the menu must be released first.
                            start_prev_reg   <= 1'b1;
                            state_reg        <= WAIT_ROLL;
                        end
                    end
                    WAIT_ROLL: begin
                        if (roll_req) begin
                            timer_reg  <= '0;
                            dice_ready <= 1'b1;
                            state_reg  <= WAIT_DICE;
                        end
                    end
                    WAIT_DICE: begin
                        if (handshake && legal) begin
                            last_roll  <= dice_value;
                            dice_ready <= 1'b0;
                            state_reg  <= MOVE;
                        end else begin
                            if (handshake) roll_err <= 1'b1;
                            if (timer_reg == CNT_LAST) begin
                                roll_err   <= 1'b1;
                                dice_ready <= 1'b0;
                                state_reg  <= WAIT_ROLL;
                            end else begin
                                timer_reg <= timer_reg + 1'b1;
                            end
                        end
                    end
                    MOVE: begin
                        pos_reg[cur_player] <= moved;
                        state_reg           <= CHECK;
                    end
                    CHECK: begin
                        if (pos_reg[cur_player] == FINISH) begin
                            winner    <= cur_player;
                            game_over <= 1'b1;
                            finished  <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            cur_player <= four_players_reg ? cur_player + 2'd1
                                                           : {1'b0, ~cur_player[0]};
                            state_reg  <= WAIT_ROLL;
                        end
                    end
                    DONE: begin
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_race_turn_controller.sv
// Scoreboard bench for race_turn_controller: stimulus queues expected output snapshots,
// a negedge monitor pops one whenever the DUT raises an event or a snapshot is requested.
module tb_race_turn_controller;

    localparam int TRACK_LEN   = 10;
    localparam int TIMEOUT_CYC = 16;
    localparam int POS_W       = 4;

    logic               clk;
    logic               reset;
    logic               is_game;
    logic               menu_select;
    logic               game_start_tick;
    logic               dice_valid;
    logic [2:0]         dice_value;
    logic               dice_ready;
    logic [1:0]         cur_player;
    logic [4*POS_W-1:0] pos;
    logic [2:0]         last_roll;
    logic               roll_err;
    logic               game_over;
    logic [1:0]         winner;
    logic               finished;

    race_turn_controller #(
        .TRACK_LEN  (TRACK_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .is_game        (is_game),
        .menu_select    (menu_select),
        .game_start_tick(game_start_tick),
        .dice_valid     (dice_valid),
        .dice_value     (dice_value),
        .dice_ready     (dice_ready),
        .cur_player     (cur_player),
        .pos            (pos),
        .last_roll      (last_roll),
        .roll_err       (roll_err),
        .game_over      (game_over),
        .winner         (winner),
        .finished       (finished)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [26:0] exp_q [$];
    string       name_q [$];
    logic        snap_req = 1'b0;
    logic        mon_en   = 1'b0;
    logic        end_req  = 1'b0;
    logic [1:0]  prev_cur = 2'd0;
    int          tests_run = 0;
    int          failed    = 0;

    wire [26:0] obs = {dice_ready, cur_player, pos, last_roll, roll_err, game_over, winner, finished};

    function automatic logic [26:0] mk(input bit dr, input int cur, input int p0, input int p1,
                                       input int p2, input int p3, input int lr, input bit err,
                                       input bit go, input int win, input bit fin);
        return {dr, 2'(cur), 4'(p3), 4'(p2), 4'(p1), 4'(p0), 3'(lr), err, go, 2'(win), fin};
    endfunction

    // Monitor: one comparison per DUT event or snapshot request.
    always @(negedge clk) begin
        logic [26:0] e;
        string       n;
        int          add_t;
        int          add_f;
        add_t = 0;
        add_f = 0;
        if (mon_en && (snap_req || roll_err || game_over || cur_player != prev_cur)) begin
            add_t = 1;
            if (exp_q.size() == 0) begin
                add_f = 1;
                $display("FAIL unexpected_event: got %h, nothing expected", obs);
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (obs !== e) begin
                    add_f = 1;
                    $display("FAIL %s: got %h expected %h", n, obs, e);
                end
            end
        end
        if (end_req) begin
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                add_t = add_t + 1;
                add_f = add_f + 1;
                $display("FAIL %s: event never seen, expected %h", n, e);
            end
        end
        prev_cur  <= cur_player;
        tests_run <= tests_run + add_t;
        failed    <= failed + add_f;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_ev(input string n, input logic [26:0] v);
        exp_q.push_back(v);
        name_q.push_back(n);
    endtask

    task automatic snap(input string n, input logic [26:0] v);
        expect_ev(n, v);
        snap_req = 1'b1;
        @(negedge clk);
        #1;
        snap_req = 1'b0;
    endtask

    // One full turn from WAIT_ROLL: press, legal handshake, then move and check.
    task automatic roll(input string n, input int v, input logic [26:0] exp_after);
        expect_ev(n, exp_after);
        game_start_tick = 1'b1;
        step(1);
        game_start_tick = 1'b0;
        dice_valid = 1'b1;
        dice_value = 3'(v);
        step(1);
        dice_valid = 1'b0;
        dice_value = 3'd0;
        step(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; is_game = 1'b0; menu_select = 1'b0;
        game_start_tick = 1'b0; dice_valid = 1'b0; dice_value = 3'd0;
        step(3);
        mon_en = 1'b1;
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            snap($sformatf("reset_idle_%0d", i), '0);
            step(1);
        end

        // Two players, normal turns
        menu_select = 1'b0; is_game = 1'b1;
        step(1);
        snap("enter_wait_roll", '0);
        step(1);
        roll("p0_roll4", 4, mk(0, 1, 4, 0, 0, 0, 4, 0, 0, 0, 0));
        roll("p1_roll6", 6, mk(0, 0, 4, 6, 0, 0, 6, 0, 0, 0, 0));

        // Timeout with no dice
        game_start_tick = 1'b1; step(1); game_start_tick = 1'b0;
        snap("dice_ready_up", mk(1, 0, 4, 6, 0, 0, 6, 0, 0, 0, 0));
        step(15);
        snap("pre_timeout", mk(1, 0, 4, 6, 0, 0, 6, 0, 0, 0, 0));
        expect_ev("timeout", mk(0, 0, 4, 6, 0, 0, 6, 1, 0, 0, 0));
        step(2);

        // Illegal value, then a legal value on the last cycle before timeout
        game_start_tick = 1'b1; step(1); game_start_tick = 1'b0;
        expect_ev("illegal7", mk(1, 0, 4, 6, 0, 0, 6, 1, 0, 0, 0));
        dice_valid = 1'b1; dice_value = 3'd7;
        step(1);
        dice_valid = 1'b0; dice_value = 3'd0;
        step(14);
        expect_ev("legal_at_last", mk(0, 1, 7, 6, 0, 0, 3, 0, 0, 0, 0));
        dice_valid = 1'b1; dice_value = 3'd3;
        step(1);
        dice_valid = 1'b0; dice_value = 3'd0;
        step(2);

        // Approach and saturating win
        roll("p1_roll1", 1, mk(0, 0, 7, 7, 0, 0, 1, 0, 0, 0, 0));
        roll("p0_roll1", 1, mk(0, 1, 8, 7, 0, 0, 1, 0, 0, 0, 0));
        roll("p1_roll2", 2, mk(0, 0, 8, 9, 0, 0, 2, 0, 0, 0, 0));
        roll("p0_win",   5, mk(0, 0, 10, 9, 0, 0, 5, 0, 1, 0, 1));
        step(1);
        snap("done_hold", mk(0, 0, 10, 9, 0, 0, 5, 0, 0, 0, 1));
        game_start_tick = 1'b1; step(1); game_start_tick = 1'b0;
        dice_valid = 1'b1; dice_value = 3'd3;
        step(2);
        dice_valid = 1'b0; dice_value = 3'd0;
        step(3);
        snap("done_ignores", mk(0, 0, 10, 9, 0, 0, 5, 0, 0, 0, 1));
        is_game = 1'b0;
        step(1);
        snap("abort_after_done", '0);

        // Start held across game entry
        game_start_tick = 1'b1; is_game = 1'b1;
        step(11);
        snap("held_no_roll", '0);
        game_start_tick = 1'b0; step(1);
        game_start_tick = 1'b1; step(1);
        game_start_tick = 1'b0;
        snap("repress_roll", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        is_game = 1'b0;
        step(1);
        snap("abort_held", '0);

        // Four players, menu changed after latch, then abort in WAIT_DICE
        menu_select = 1'b1; is_game = 1'b1;
        step(1);
        menu_select = 1'b0;
        step(1);
        roll("four_p0", 1, mk(0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        roll("four_p1", 1, mk(0, 2, 1, 1, 0, 0, 1, 0, 0, 0, 0));
        roll("four_p2", 1, mk(0, 3, 1, 1, 1, 0, 1, 0, 0, 0, 0));
        roll("four_p3", 1, mk(0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0));
        game_start_tick = 1'b1; step(1); game_start_tick = 1'b0;
        snap("four_wait_dice", mk(1, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0));
        is_game = 1'b0;
        step(1);
        snap("four_abort", '0);

        // Reset while waiting for dice
        is_game = 1'b1;
        step(2);
        game_start_tick = 1'b1; step(1); game_start_tick = 1'b0;
        reset = 1'b1;
        step(1);
        snap("reset_mid", '0);
        reset = 1'b0; is_game = 1'b0;
        step(2);

        end_req = 1'b1;
        @(negedge clk);
        #1;
        end_req = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
